// File: rtl/slice_block_writer_pkg.sv
// Shared constants and types for the slice writer and the 8x8 block fetch stage.
// Pure declarations: no latency, no flow control.
package slice_block_writer_pkg;

  localparam int BLOCK_DIM        = 8;
  localparam int PIXELS_PER_BLOCK = 64;
  localparam int BLOCKS_PER_MB    = 4;
  localparam int MB_DIM           = 16;
  localparam int MAX_BLOCK_NUM    = 32;
  localparam int MEM_WORDS        = 4096;
  localparam int BANK_WORDS       = 2048;

  localparam int ADDR_W = 12;
  localparam int PIX_W  = 16;
  localparam int X_W    = 7;
  localparam int Y_W    = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pix_t;

  typedef struct packed {
    logic        en;
    addr_t       addr;
    logic [31:0] dat;
  } wr_t;

endpackage

// File: rtl/slice_block_writer_if.sv
// Pixel stream, memory write port and bank handshake between writer and its neighbours.
// slave = the writer, master = producer/memory/consumer side.
interface slice_block_writer_if;
  import slice_block_writer_pkg::*;

  logic        pixel_valid;
  pix_t        pixel_data;
  logic        pixel_ready;
  logic        mem_wr_en;
  addr_t       mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        bank_valid;
  logic [31:0] bank_offset;
  logic        bank_done;
  logic        bank_release;
  logic        release_error;

  modport slave (
    input  pixel_valid, pixel_data, bank_release,
    output pixel_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
           bank_valid, bank_offset, bank_done, release_error
  );

  modport master (
    output pixel_valid, pixel_data, bank_release,
    input  pixel_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
           bank_valid, bank_offset, bank_done, release_error
  );

endinterface

// File: rtl/slice_block_writer_block_addr_gen.sv
// Raster (x, y, bank) to block-order word address; purely combinational, no flow control.
// Layout: bank | macroblock | block row | block col | row in block | col in block.
module block_addr_gen
  import slice_block_writer_pkg::*;
(
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           bank,
  output addr_t          addr
);

  logic [4:0] blk;

  // blk = mb*4 + (y>>3)*2 + ((x>>3)&1); every term is a power of two so it packs as bit fields
  assign blk  = {x[6:4], y[3], x[3]};
  assign addr = {bank, blk, y[2:0], x[2:0]};

endmodule

// File: rtl/slice_block_writer.sv
// Writes a raster luma slice into ping-pong banks in 8x8 block order; write issued 1 cycle after accept.
// pixel_ready drops while the bank being filled is still unreleased; bank_release frees the oldest bank.
module slice_block_writer
  import slice_block_writer_pkg::*;
#(
  parameter int MB_PER_SLICE = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  slice_block_writer_if.slave  bus
);

  localparam int X_MAX = MB_PER_SLICE * MB_DIM - 1;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]     state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           wr_bank;
  logic           wr_bank_nxt;
  logic           rd_bank;
  logic [1:0]     full;
  logic [1:0]     full_nxt;
  logic           accept;
  logic           last_pix;
  logic           complete;
  logic           rel_ok;
  addr_t          pix_addr;
  wr_t            wr_q;
  logic           done_q;
  logic           rel_err_q;

  block_addr_gen u_addr_gen (
    .x    (x),
    .y    (y),
    .bank (wr_bank),
    .addr (pix_addr)
  );

  assign accept      = bus.pixel_valid && (state == ST_FILL);
  assign last_pix    = (x == X_W'(X_MAX)) && (y == 4'd15);
  assign complete    = accept && last_pix;
  assign rel_ok      = bus.bank_release && (|full);
  assign wr_bank_nxt = wr_bank ^ complete;

  // A completing bank and a released bank can never collide: completion needs full[wr_bank]=0,
  // a valid release needs full[rd_bank]=1.
  always_comb begin
    full_nxt = full;
    if (complete) full_nxt[wr_bank] = 1'b1;
    if (rel_ok)   full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RESET;
      x         <= '0;
      y         <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      wr_q      <= '0;
      done_q    <= 1'b0;
      rel_err_q <= 1'b0;
    end else begin
      state   <= full_nxt[wr_bank_nxt] ? ST_STALL : ST_FILL;
      full    <= full_nxt;
      wr_bank <= wr_bank_nxt;
      rd_bank <= rd_bank ^ rel_ok;
      wr_q.en <= accept;
      done_q  <= complete;
      if (accept) begin
        wr_q.addr <= pix_addr;
        wr_q.dat  <= {16'h0, bus.pixel_data};
        if (x == X_W'(X_MAX)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (bus.bank_release && !(|full)) rel_err_q <= 1'b1;
    end
  end

  assign bus.pixel_ready   = (state == ST_FILL);
  assign bus.mem_wr_en     = wr_q.en;
  assign bus.mem_wr_addr   = wr_q.addr;
  assign bus.mem_wr_data   = wr_q.dat;
  assign bus.bank_done     = done_q;
  assign bus.bank_valid    = |full;
  assign bus.bank_offset   = ((|full) && rd_bank) ? 32'(BANK_WORDS) : 32'd0;
  assign bus.release_error = rel_err_q;

endmodule

// File: tb/tb_slice_block_writer.sv
// Directed bench for slice_block_writer with a write scoreboard fed at beat acceptance.
module tb_slice_block_writer;
  import slice_block_writer_pkg::*;

  localparam int MB    = 8;
  localparam int W     = MB * 16;
  localparam int SLICE = W * 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  slice_block_writer_if bus();

  slice_block_writer #(.MB_PER_SLICE(MB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int dat;
    bit done;
  } exp_t;

  exp_t        sb[$];
  int          checks     = 0;
  int          errors     = 0;
  int          wr_count   = 0;
  int          done_count = 0;
  int          mx = 0, my = 0, mbank = 0, base = 0;
  logic [31:0] tb_mem [MEM_WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_addr(input int px, input int py, input int pb);
    int blk;
    blk = (px / 16) * 4 + (py / 8) * 2 + ((px / 8) % 2);
    return pb * 2048 + blk * 64 + (py % 8) * 8 + (px % 8);
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.mem_wr_en) begin
        check("write_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("wr_addr", 32'(bus.mem_wr_addr), e.addr);
          check("wr_data", bus.mem_wr_data, e.dat);
          check("done_align", 32'(bus.bank_done), 32'(e.done));
        end
        tb_mem[bus.mem_wr_addr] = bus.mem_wr_data;
        wr_count++;
        if (bus.bank_done) done_count++;
      end else begin
        check("done_idle", 32'(bus.bank_done), 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_release();
    bus.bank_release = 1'b1;
    @(negedge clock);
    bus.bank_release = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit gaps, input bit rel_last);
    for (int i = 0; i < n; i++) begin
      int budget;
      bit is_last;
      int pix;
      budget = 0;
      if (gaps) begin
        while (($urandom & 1) == 0) begin
          bus.pixel_valid = 1'b0;
          bus.pixel_data  = 16'($urandom);
          @(negedge clock);
        end
      end
      pix = (base + mx + my * W) & 32'hffff;
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = 16'(pix);
      while (!bus.pixel_ready && budget < 200) begin
        @(negedge clock);
        budget++;
      end
      if (!bus.pixel_ready) begin
        check("ready_timeout", 32'(bus.pixel_ready), 1);
        bus.pixel_valid = 1'b0;
        return;
      end
      is_last = (mx == W - 1) && (my == 15);
      sb.push_back('{ref_addr(mx, my, mbank), pix, is_last});
      if (rel_last && is_last) bus.bank_release = 1'b1;
      if (mx == W - 1) begin
        mx = 0;
        if (my == 15) begin
          my    = 0;
          mbank = mbank ^ 1;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      @(negedge clock);
      bus.bank_release = 1'b0;
    end
    bus.pixel_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int wr0;
    int d0;
    bus.pixel_valid  = 1'b0;
    bus.pixel_data   = '0;
    bus.bank_release = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] = 32'hdeadbeef;

    // reset values
    idle(3);
    check("ready_in_reset", 32'(bus.pixel_ready), 0);
    reset_n = 1'b1;
    idle(2);
    check("rst_ready", 32'(bus.pixel_ready), 1);
    check("rst_bank_valid", 32'(bus.bank_valid), 0);
    check("rst_offset", bus.bank_offset, 0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 0);
    check("rst_rel_err", 32'(bus.release_error), 0);

    // first slice, continuous, into bank 0
    send_beats(SLICE, 1'b0, 1'b0);
    idle(2);
    check("s1_writes", wr_count, 2048);
    check("s1_done", done_count, 1);
    check("s1_bank_valid", 32'(bus.bank_valid), 1);
    check("s1_offset", bus.bank_offset, 0);
    check("mem_17_9", tb_mem[393], 1169);
    check("mem_0_0", tb_mem[0], 0);
    check("mem_127_15", tb_mem[2047], 2047);

    // second slice into bank 1, then both banks full
    base = 4096;
    send_beats(SLICE, 1'b0, 1'b0);
    idle(2);
    check("s2_writes", wr_count, 4096);
    check("s2_done", done_count, 2);
    check("s2_first", tb_mem[2048], 4096);
    check("s2_last", tb_mem[4095], 4096 + 2047);
    check("s2_17_9", tb_mem[2048 + 393], 4096 + 1169);
    check("stall_ready", 32'(bus.pixel_ready), 0);
    check("s2_offset", bus.bank_offset, 0);

    // third slice's first beat is held until a release
    base = 0;
    tb_mem[0] = 32'hdeadbeef;
    bus.pixel_valid = 1'b1;
    bus.pixel_data  = 16'd0;
    idle(4);
    check("held_no_write", wr_count, 4096);
    check("held_ready", 32'(bus.pixel_ready), 0);
    pulse_release();
    check("rel_offset", bus.bank_offset, 2048);
    check("rel_ready", 32'(bus.pixel_ready), 1);
    send_beats(1, 1'b0, 1'b0);
    idle(1);
    check("held_written", wr_count, 4097);
    check("held_addr0", tb_mem[0], 0);

    // rest of third slice with 50% valid duty
    send_beats(SLICE - 1, 1'b1, 1'b0);
    idle(2);
    check("s3_writes", wr_count, 6144);
    check("s3_done", done_count, 3);
    check("s3_bank_valid", 32'(bus.bank_valid), 1);
    check("s3_offset", bus.bank_offset, 2048);
    bad = 0;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < W; xx++)
        if (tb_mem[ref_addr(xx, yy, 0)] !== 32'(xx + yy * W)) bad++;
    check("gap_image", bad, 0);

    // drain both banks, then an illegal release
    pulse_release();
    check("drain1_offset", bus.bank_offset, 0);
    check("drain1_valid", 32'(bus.bank_valid), 1);
    pulse_release();
    check("drain2_valid", 32'(bus.bank_valid), 0);
    check("drain2_offset", bus.bank_offset, 0);
    check("no_err_yet", 32'(bus.release_error), 0);
    pulse_release();
    check("rel_err_set", 32'(bus.release_error), 1);
    idle(3);
    check("rel_err_sticky", 32'(bus.release_error), 1);

    // reset in the middle of a slice
    send_beats(1000, 1'b0, 1'b0);
    idle(2);
    check("partial_writes", wr_count, 6144 + 1000);
    reset_n = 1'b0;
    @(negedge clock);
    sb.delete();
    mx = 0;
    my = 0;
    mbank = 0;
    reset_n = 1'b1;
    idle(2);
    check("mid_rst_err", 32'(bus.release_error), 0);
    check("mid_rst_valid", 32'(bus.bank_valid), 0);
    check("mid_rst_ready", 32'(bus.pixel_ready), 1);
    wr0 = wr_count;
    d0  = done_count;
    base = 8192;
    send_beats(SLICE, 1'b0, 1'b0);
    idle(2);
    check("post_rst_writes", wr_count, wr0 + 2048);
    check("post_rst_done", done_count, d0 + 1);
    check("post_rst_addr0", tb_mem[0], 8192);

    // release on the same edge the second bank completes
    base = 12288;
    send_beats(SLICE, 1'b0, 1'b1);
    idle(2);
    check("sim_done", done_count, d0 + 2);
    check("sim_valid", 32'(bus.bank_valid), 1);
    check("sim_offset", bus.bank_offset, 2048);
    check("sim_ready", 32'(bus.pixel_ready), 1);
    check("sim_no_err", 32'(bus.release_error), 0);
    pulse_release();
    check("sim_one_full", 32'(bus.bank_valid), 0);
    check("sim_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
